// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, key-length codes, GF(2^8) column mixing
// and byte-position helpers for the byte-0-at-[7:0] block layout.
package aes_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [3:0] NK_128 = 4'd4;
   localparam logic [3:0] NK_192 = 4'd6;
   localparam logic [3:0] NK_256 = 4'd8;
   localparam logic [3:0] NR_OFS = 4'd6;

   function automatic logic nk_legal(input logic [3:0] nk);
      return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row 0 of the column lives in [7:0]
   function automatic logic [31:0] mixcolumn(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3, t;
      a0 = col[7:0];
      a1 = col[15:8];
      a2 = col[23:16];
      a3 = col[31:24];
      t  = a0 ^ a1 ^ a2 ^ a3;
      return {a3 ^ t ^ xtime(a3 ^ a0),
              a2 ^ t ^ xtime(a2 ^ a3),
              a1 ^ t ^ xtime(a1 ^ a2),
              a0 ^ t ^ xtime(a0 ^ a1)};
   endfunction

   function automatic int unsigned byte_lsb(input int unsigned row,
                                            input int unsigned col);
      return 8 * (row + 4 * col);
   endfunction

   function automatic int unsigned word_lsb(input int unsigned col);
      return 32 * col;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a constant lookup table.
module aes_sbox (
   input  logic [7:0] i_a,
   output logic [7:0] o_y
);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte of the packed constant
   logic [7:0] w_idx;

   assign w_idx = 8'hff - i_a;
   assign o_y   = SBOX[{w_idx, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 encryption core, one round per clock, round keys
// fetched combinationally from the key-expansion block through Addr.
module aes_encrypt_core
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   Nk,
   input  logic         k_ready,
   output logic [3:0]   Addr,
   input  logic [127:0] ex_key,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext
);

   state_t       r_state, w_state_nxt;
   logic [3:0]   r_rnd, w_rnd_nxt;
   logic [3:0]   r_nr, w_nr_nxt;
   logic [127:0] r_st, w_st_nxt;
   logic [127:0] w_sb, w_sr, w_mc;
   logic         w_accept, w_last;

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_sbox u_sbox (
         .i_a (r_st[8*i +: 8]),
         .o_y (w_sb[8*i +: 8])
      );
   end

   // Row r of column c takes the byte from column (c + r) mod 4
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_sr[byte_lsb(r, c) +: 8] =
            w_sb[byte_lsb(r, (c + r) % 4) +: 8];
      end
      assign w_mc[word_lsb(c) +: 32] = mixcolumn(w_sr[word_lsb(c) +: 32]);
   end

   assign in_ready   = ~rst & (r_state == S_IDLE) & k_ready & nk_legal(Nk);
   assign w_accept   = in_valid & in_ready;
   assign w_last     = (r_rnd == r_nr);
   assign Addr       = (r_state == S_ROUND) ? r_rnd : 4'd0;
   assign out_valid  = (r_state == S_DONE);
   assign ciphertext = out_valid ? r_st : '0;

   always_comb begin
      w_state_nxt = r_state;
      w_rnd_nxt   = r_rnd;
      w_nr_nxt    = r_nr;
      w_st_nxt    = r_st;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_st_nxt    = plaintext ^ ex_key;
               w_nr_nxt    = Nk + NR_OFS;
               w_rnd_nxt   = 4'd1;
               w_state_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            // Losing the key schedule mid-block discards the block
            if (!k_ready) begin
               w_st_nxt    = '0;
               w_rnd_nxt   = 4'd0;
               w_state_nxt = S_IDLE;
            end else if (w_last) begin
               w_st_nxt    = w_sr ^ ex_key;
               w_rnd_nxt   = 4'd0;
               w_state_nxt = S_DONE;
            end else begin
               w_st_nxt  = w_mc ^ ex_key;
               w_rnd_nxt = r_rnd + 4'd1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rnd   <= 4'd0;
         r_nr    <= 4'd0;
         r_st    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rnd   <= w_rnd_nxt;
         r_nr    <= w_nr_nxt;
         r_st    <= w_st_nxt;
      end
   end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core with a byte-array AES reference model
// and an S-box derived from GF(2^8) inversion plus the affine map.
module tb_aes_encrypt_core;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   Nk;
   logic         k_ready;
   logic [3:0]   Addr;
   logic [127:0] ex_key;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;

   aes_encrypt_core dut (
      .clk        (clk),
      .rst        (rst),
      .Nk         (Nk),
      .k_ready    (k_ready),
      .Addr       (Addr),
      .ex_key     (ex_key),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] ct;
      int           cyc;
   } exp_t;

   logic [127:0] rk [16];
   logic [7:0]   sbt [256];
   exp_t         sb [$];
   exp_t         acc_e, out_e;
   int           vecs = 0;
   int           errs = 0;
   int           cyc = 0;
   logic         ready_mode, ready_val, rnd_rdy;
   logic         use_fixed;
   logic [127:0] fixed_ct, held;
   logic         prev_ov = 1'b0;

   assign ex_key    = rk[Addr];
   assign out_ready = ready_mode ? rnd_rdy : ready_val;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1 rnd_rdy = 1'($urandom_range(0, 1));
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [255:0] key, input int nk);
      logic [7:0] w [60][4];
      logic [7:0] t [4];
      logic [7:0] tmp, rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++)
         for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
      for (int i = nk; i < 4 * (nk + 7); i++) begin
         for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
         if (i % nk == 0) begin
            tmp  = t[0];
            t[0] = sbt[t[1]] ^ rc;
            t[1] = sbt[t[2]];
            t[2] = sbt[t[3]];
            t[3] = sbt[tmp];
            rc   = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            for (int j = 0; j < 4; j++) t[j] = sbt[t[j]];
         end
         for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ t[j];
      end
      for (int r = 0; r < 16; r++) rk[r] = '0;
      for (int r = 0; r <= nk + 6; r++)
         for (int k = 0; k < 16; k++) rk[r][8*k +: 8] = w[4*r + k/4][k%4];
   endtask

   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk[0][8*i +: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbt[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*c] = s[w + 4*((c+w)%4)];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               if (r < nr)
                  s[w+4*c] = gmul(8'h02, t[w+4*c]) ^ gmul(8'h03, t[(w+1)%4+4*c])
                           ^ t[(w+2)%4+4*c] ^ t[(w+3)%4+4*c];
               else
                  s[w+4*c] = t[w+4*c];
         for (int i = 0; i < 16; i++) s[i] ^= rk[r%16][8*i +: 8];
      end
      for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
      return o;
   endfunction

   function automatic logic [127:0] rev16(input logic [127:0] x);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = x[8*(15-i) +: 8];
      return o;
   endfunction

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] expv);
      vecs++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic fail_now(input string name);
      vecs++;
      errs++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Accept side of the scoreboard
   always @(negedge clk) begin
      if (!rst && in_valid && in_ready) begin
         acc_e.ct  = use_fixed ? fixed_ct : ref_enc(plaintext, int'(Nk) + 6);
         acc_e.cyc = cyc + int'(Nk) + 7;
         sb.push_back(acc_e);
      end
   end

   // Output side: first valid cycle pops and compares, later cycles check hold
   always @(negedge clk) begin
      if (out_valid) begin
         if (!prev_ov) begin
            if (sb.size() == 0) begin
               vecs++;
               errs++;
               $display("FAIL unexpected_output: got %h expected none", ciphertext);
            end else begin
               out_e = sb.pop_front();
               chk("ciphertext", ciphertext, out_e.ct);
               chk("latency", 128'(cyc), 128'(out_e.cyc));
            end
            held = ciphertext;
         end else begin
            chk("hold_ct", ciphertext, held);
         end
         prev_ov = !out_ready;
      end else begin
         prev_ov = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [127:0] pt, input logic [3:0] nk);
      in_valid  = 1'b1;
      plaintext = pt;
      Nk        = nk;
   endtask

   task automatic await_accept(output int acc);
      acc = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = cyc;
            break;
         end
      end
      tick();
      in_valid = 1'b0;
      if (acc < 0) fail_now("accept_timeout");
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("drain_timeout");
      tick();
   endtask

   task automatic wait_addr(input logic [3:0] v);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (Addr == v) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("addr_timeout");
   endtask

   function automatic logic [3:0] pick_nk();
      case ($urandom_range(0, 2))
         0:       return 4'd4;
         1:       return 4'd6;
         default: return 4'd8;
      endcase
   endfunction

   initial begin
      logic [255:0] fkey, rkey;
      logic [127:0] fpt, c1;
      logic [127:0] fct [3];
      logic [3:0]   nk;
      int           acc, acc2, h;
      bit           seen;

      rst = 1'b1; k_ready = 1'b1; in_valid = 1'b0; plaintext = '0; Nk = 4'd4;
      ready_mode = 1'b0; ready_val = 1'b1; rnd_rdy = 1'b1;
      use_fixed = 1'b0; fixed_ct = '0; held = '0;
      for (int r = 0; r < 16; r++) rk[r] = '0;
      build_sbox();
      for (int i = 0; i < 32; i++) fkey[8*i +: 8] = 8'(i);
      for (int i = 0; i < 16; i++) fpt[8*i +: 8] = 8'(i * 17);
      fct[0] = rev16(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      fct[1] = rev16(128'hdda97ca4864cdfe06eaf70a0ec0d7191);
      fct[2] = rev16(128'h8ea2b7ca516745bfeafc49904b496089);
      c1 = fct[0];

      tick();
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_addr", 128'(Addr), 128'd0);
      chk("rst_ct", ciphertext, 128'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 128'(in_ready), 128'd1);
      tick();

      for (int k = 0; k < 3; k++) begin
         nk = 4'(4 + 2 * k);
         expand(fkey, int'(nk));
         use_fixed = 1'b1;
         fixed_ct  = fct[k];
         offer(fpt, nk);
         await_accept(acc);
         use_fixed = 1'b0;
         Nk = 4'($urandom);
         drain();
      end

      expand(fkey, 4);
      offer(fpt ^ 128'h5a, 4'd4);
      await_accept(acc);
      offer(fpt ^ 128'ha5, 4'd4);
      await_accept(acc2);
      chk("throughput", 128'(acc2 - acc), 128'd12);
      drain();

      ready_val = 1'b0;
      offer({$urandom, $urandom, $urandom, $urandom}, 4'd4);
      await_accept(acc);
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail_now("bp_out_valid_timeout");
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
         chk("bp_out_valid", 128'(out_valid), 128'd1);
      end
      tick();
      offer({$urandom, $urandom, $urandom, $urandom}, 4'd4);
      ready_val = 1'b1;
      h = cyc;
      await_accept(acc);
      chk("bp_next_accept", 128'(acc), 128'(h + 1));
      drain();

      offer(fpt, 4'd4);
      await_accept(acc);
      wait_addr(4'd5);
      k_ready = 1'b0;
      @(negedge clk);
      chk("abort_addr", 128'(Addr), 128'd0);
      chk("abort_out_valid", 128'(out_valid), 128'd0);
      chk("abort_in_ready", 128'(in_ready), 128'd0);
      if (sb.size() > 0) void'(sb.pop_back());
      repeat (15) @(negedge clk);
      tick();
      k_ready = 1'b1;
      offer(fpt, 4'd5);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("nk5_in_ready", 128'(in_ready), 128'd0);
      end
      tick();
      Nk = 4'd4;
      k_ready = 1'b0;
      @(negedge clk);
      chk("kready0_in_ready", 128'(in_ready), 128'd0);
      tick();
      k_ready = 1'b1;
      use_fixed = 1'b1;
      fixed_ct  = c1;
      await_accept(acc);
      use_fixed = 1'b0;
      drain();

      offer(fpt, 4'd4);
      await_accept(acc);
      wait_addr(4'd7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rrst_addr", 128'(Addr), 128'd0);
      chk("rrst_out_valid", 128'(out_valid), 128'd0);
      chk("rrst_ct", ciphertext, 128'd0);
      chk("rrst_in_ready", 128'(in_ready), 128'd1);
      if (sb.size() > 0) void'(sb.pop_back());
      tick();
      use_fixed = 1'b1;
      fixed_ct  = c1;
      offer(fpt, 4'd4);
      await_accept(acc);
      use_fixed = 1'b0;
      drain();

      ready_mode = 1'b1;
      for (int n = 0; n < 25; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
         nk = pick_nk();
         expand(rkey, int'(nk));
         offer({$urandom, $urandom, $urandom, $urandom}, nk);
         await_accept(acc);
         Nk = 4'($urandom);
         drain();
      end
      ready_mode = 1'b0;
      drain();
      chk("scoreboard_empty", 128'(sb.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
